// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit and its return-address stack.
package pc_pkg;

    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_RET,
        NPC_CALL,
        NPC_BR,
        NPC_INC
    } npc_sel_t;

    // Pointer width for a power-of-two RAS; the count needs one extra bit to reach DEPTH.
    function automatic int ras_ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push at top, pop from top-1, oldest entry overwritten when full.
module pc_ras
    import pc_pkg::*;
#(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         empty,
    output logic         full
);

    localparam int PW = ras_ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] top_reg, top_next;
    logic [CW-1:0] count_reg, count_next;
    logic [W-1:0]  entry_reg [DEPTH];
    logic [PW-1:0] top_m1;
    logic          do_pop, do_push;

    assign top_m1   = top_reg - PW'(1);
    assign top_data = entry_reg[top_m1];
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && !pop;

    always_comb begin
        top_next   = top_reg;
        count_next = count_reg;
        if (do_pop) begin
            top_next   = top_m1;
            count_next = count_reg - CW'(1);
        end else if (do_push) begin
            top_next = top_reg + PW'(1);
            // Saturate the count; the pointer keeps going, so the oldest slot is reused.
            if (!full)
                count_next = count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_reg   <= '0;
            count_reg <= '0;
        end else begin
            top_reg   <= top_next;
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst)
                    entry_reg[gi] <= '0;
                else if (do_push && top_reg == PW'(gi))
                    entry_reg[gi] <= push_data;
            end
        end
    endgenerate

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select (stall/ret/call/branch/increment), target adder, RAS.
// Optional sticky RAS under/overflow flag on port ras_err when PC_RAS_ERR_EN is defined.
module pc_unit
    import pc_pkg::*;
#(
    parameter int PC_W      = 5,
    parameter int RESET_VEC = 0,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_en,
    input  logic            br_rel,
    input  logic [PC_W-1:0] br_tgt,
    input  logic            call,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus,
    output logic            ras_empty,
    output logic            ras_full
`ifdef PC_RAS_ERR_EN
    ,
    output logic            ras_err
`endif
);

    npc_sel_t        sel;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] ras_top;
    logic            push, pop;

    assign pc      = pc_reg;
    assign pc_plus = pc_reg + PC_W'(STEP);
    assign target  = br_rel ? (pc_reg + br_tgt) : br_tgt;
    assign push    = (sel == NPC_CALL);
    assign pop     = (sel == NPC_RET);

    always_comb begin
        sel = NPC_INC;
        if (stall)
            sel = NPC_HOLD;
        else if (ret)
            sel = ras_empty ? NPC_INC : NPC_RET;  // underflow falls through to increment
        else if (call)
            sel = NPC_CALL;
        else if (br_en)
            sel = NPC_BR;
    end

    always_comb begin
        pc_next = pc_plus;
        case (sel)
            NPC_HOLD: pc_next = pc_reg;
            NPC_RET:  pc_next = ras_top;
            NPC_CALL: pc_next = target;
            NPC_BR:   pc_next = target;
            default:  pc_next = pc_plus;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_reg <= PC_W'(RESET_VEC);
        else
            pc_reg <= pc_next;
    end

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

`ifdef PC_RAS_ERR_EN
    logic err_reg, err_next;

    always_comb begin
        err_next = err_reg;
        if (!stall && ret && ras_empty)
            err_next = 1'b1;
        if (sel == NPC_CALL && ras_full)
            err_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_reg <= 1'b0;
        else
            err_reg <= err_next;
    end

    assign ras_err = err_reg;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random control traffic against a queue-based model.
module tb_pc_unit;

    localparam int PC_W      = 5;
    localparam int RESET_VEC = 0;
    localparam int STEP      = 1;
    localparam int RAS_DEPTH = 4;
    localparam int MOD       = 1 << PC_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stall = 1'b0, br_en = 1'b0, br_rel = 1'b0, call = 1'b0, ret = 1'b0;
    logic [PC_W-1:0] br_tgt = '0;
    logic [PC_W-1:0] pc, pc_plus;
    logic            ras_empty, ras_full;
`ifdef PC_RAS_ERR_EN
    logic            ras_err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: PC as an integer, RAS as a bounded queue (oldest at front).
    int m_pc = RESET_VEC;
    int m_q[$];
    bit m_err = 1'b0;

    pc_unit #(
        .PC_W      (PC_W),
        .RESET_VEC (RESET_VEC),
        .STEP      (STEP),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_en     (br_en),
        .br_rel    (br_rel),
        .br_tgt    (br_tgt),
        .call      (call),
        .ret       (ret),
        .pc        (pc),
        .pc_plus   (pc_plus),
        .ras_empty (ras_empty),
        .ras_full  (ras_full)
`ifdef PC_RAS_ERR_EN
        ,
        .ras_err   (ras_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit be, input bit rel,
                              input int tgt, input bit c, input bit rt);
        int t;
        t = rel ? (m_pc + tgt) % MOD : tgt;
        if (r) begin
            m_pc = RESET_VEC;
            m_q.delete();
            m_err = 1'b0;
        end else if (s) begin
            // frozen
        end else if (rt) begin
            if (m_q.size() > 0) begin
                m_pc = m_q.pop_back();
            end else begin
                m_pc  = (m_pc + STEP) % MOD;
                m_err = 1'b1;
            end
        end else if (c) begin
            if (m_q.size() == RAS_DEPTH) begin
                void'(m_q.pop_front());
                m_err = 1'b1;
            end
            m_q.push_back((m_pc + STEP) % MOD);
            m_pc = t;
        end else if (be) begin
            m_pc = t;
        end else begin
            m_pc = (m_pc + STEP) % MOD;
        end
    endtask

    // One transaction: drive at negedge, clock, update model, compare 1 time unit after the edge.
    task automatic go(input bit r, input bit s, input bit be, input bit rel,
                      input int tgt, input bit c, input bit rt);
        @(negedge clk);
        rst = r; stall = s; br_en = be; br_rel = rel; br_tgt = PC_W'(tgt); call = c; ret = rt;
        @(posedge clk);
        model_step(r, s, be, rel, tgt, c, rt);
        #1;
        cyc++;
        check("pc", int'(pc), m_pc);
        check("pc_plus", int'(pc_plus), (m_pc + STEP) % MOD);
        check("ras_empty", int'(ras_empty), int'(m_q.size() == 0));
        check("ras_full", int'(ras_full), int'(m_q.size() == RAS_DEPTH));
`ifdef PC_RAS_ERR_EN
        check("ras_err", int'(ras_err), int'(m_err));
`endif
        $display("cyc=%0d rst=%0b stall=%0b br=%0b rel=%0b tgt=%0d call=%0b ret=%0b -> pc=%0d ras_n=%0d",
                 cyc, r, s, be, rel, tgt, c, rt, pc, m_q.size());
    endtask

    task automatic inc(input int n);
        for (int i = 0; i < n; i++) go(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // 1: reset two cycles, free-run through the wrap
        go(1, 0, 0, 0, 0, 0, 0);
        go(1, 0, 0, 0, 0, 0, 0);
        check("s1_reset_pc", int'(pc), 0);
        for (int i = 0; i < 33; i++) begin
            go(0, 0, 0, 0, 0, 0, 0);
            check("s1_empty", int'(ras_empty), 1);
            if (i == 31) check("s1_wrap", int'(pc), 0);
        end

        // 2: relative then absolute branch
        go(1, 0, 0, 0, 0, 0, 0);
        inc(5);
        check("s2_at5", int'(pc), 5);
        go(0, 0, 1, 1, 29, 0, 0);
        check("s2_rel", int'(pc), 2);
        go(0, 0, 1, 0, 20, 0, 0);
        check("s2_abs", int'(pc), 20);

        // 3: nested call/ret
        go(1, 0, 0, 0, 0, 0, 0);
        inc(3);
        go(0, 0, 0, 0, 10, 1, 0);
        check("s3_call1", int'(pc), 10);
        check("s3_nonempty", int'(ras_empty), 0);
        inc(2);
        go(0, 0, 0, 0, 25, 1, 0);
        check("s3_call2", int'(pc), 25);
        go(0, 0, 0, 0, 0, 0, 1);
        check("s3_ret1", int'(pc), 13);
        go(0, 0, 0, 0, 0, 0, 1);
        check("s3_ret2", int'(pc), 4);
        check("s3_empty", int'(ras_empty), 1);

        // 4: overflow and underflow
        go(1, 0, 0, 0, 0, 0, 0);
        inc(1);
        for (int i = 1; i <= 5; i++) begin
            go(0, 0, 0, 0, i + 1, 1, 0);
            if (i == 4) check("s4_full", int'(ras_full), 1);
        end
        for (int i = 0; i < 4; i++) begin
            go(0, 0, 0, 0, 0, 0, 1);
            check("s4_ret", int'(pc), 6 - i);
        end
        go(0, 0, 0, 0, 0, 0, 1);
        check("s4_underflow", int'(pc), 4);
`ifdef PC_RAS_ERR_EN
        check("s4_err", int'(ras_err), 1);
`endif

        // 5: stall overrides everything, then a plain branch
        go(0, 0, 0, 0, 9, 1, 0);
        for (int i = 0; i < 3; i++) begin
            go(0, 1, 1, 0, 30, 1, 1);
            check("s5_hold", int'(pc), 9);
        end
        go(0, 0, 1, 0, 7, 0, 0);
        check("s5_release", int'(pc), 7);

        // 6: reset beats stall and call
        go(1, 0, 0, 0, 0, 0, 0);
        inc(17);
        check("s6_at17", int'(pc), 17);
        go(1, 1, 0, 0, 3, 1, 0);
        check("s6_pc", int'(pc), 0);
        check("s6_empty", int'(ras_empty), 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            go($urandom_range(49) == 0, $urandom_range(5) == 0, $urandom_range(3) == 0,
               1'($urandom), int'($urandom_range(MOD - 1)),
               $urandom_range(3) == 0, $urandom_range(3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
